fractal_pixel_scheduler: RTL and testbench
==========================================

// Module: fractal_pixel_scheduler
// PURPOSE
//  Raster-order scheduler between the fractal iteration cores and the pixel stream packer.
//  Issues (x,y) pixel coordinates round-robin to N_CORES iteration engines.
//  Collects their iteration counts in the same round-robin order, so output is strictly raster order.
//  Emits one pixel per beat with AXI-Stream-style tuser (start of frame) and tlast (end of line).
// PARAMETERS
//  X_PIX    640  pixels per line
//  Y_PIX    480  lines per frame
//  N_CORES  4    number of iteration cores (>=1)
//  COORD_W  10   coordinate width; must hold X_PIX-1 and Y_PIX-1
//  ITER_W   8    iteration-count width
// PORTS
//  out_stream_aclk  in   1               single clock, all logic posedge
//  periph_resetn    in   1               asynchronous active-low reset
//  enable           in   1               level; high = run frames back to back
//  core_req_valid   out  N_CORES         one-hot request to core dp
//  core_req_x       out  COORD_W         shared x coordinate, qualified by core_req_valid
//  core_req_y       out  COORD_W         shared y coordinate, qualified by core_req_valid
//  core_req_ready   in   N_CORES         per-core accept
//  core_res_valid   in   N_CORES         per-core result valid
//  core_res_iter    in   N_CORES*ITER_W  core k result in bits [k*ITER_W +: ITER_W]
//  core_res_ready   out  N_CORES         one-hot accept to core cp
//  pix_tdata        out  ITER_W          iteration count of current pixel
//  pix_tvalid       out  1               pixel valid
//  pix_tready       in   1               downstream accept
//  pix_tuser        out  1               high on pixel (0,0) only
//  pix_tlast        out  1               high on x==X_PIX-1
//  busy             out  1               state != IDLE
//  frame_done       out  1               1-cycle pulse when the last pixel of a frame is accepted
// BEHAVIOUR
//  Reset: all outputs 0. State=IDLE. Pointers dp,cp=0. Counters (dx,dy,ox,oy)=0. inflight[]=0.
//  Reset is asynchronous and may occur mid-frame: everything clears, and the next frame restarts at (0,0).
//  The cores share this reset.
//  FSM:
//   IDLE -> RUN   when enable=1.
//   RUN  -> DRAIN after the handshake issuing pixel (X_PIX-1,Y_PIX-1).
//   DRAIN -> RUN  (counters cleared) on the frame_done cycle if enable=1.
//   DRAIN -> IDLE on the frame_done cycle if enable=0.
//   enable=0 mid-frame does not abort: the current frame completes, then IDLE.
//  Dispatch (RUN only):
//   - core_req_valid[dp]=1 iff !inflight[dp]; all other bits 0.
//   - core_req_x=dx, core_req_y=dy, combinational from registers.
//   - Handshake when valid&ready: set inflight[dp], dp=(dp+1)%N_CORES, advance dx; dx wraps to 0 and dy increments at X_PIX-1.
//   - Each core holds at most 1 outstanding pixel, which guarantees raster order.
//  Collect:
//   - core_res_ready[cp]=1 iff inflight[cp] && (!pix_tvalid || pix_tready); all other bits 0.
//   - On result handshake: load pix_tdata from slice cp; pix_tuser=(ox==0&&oy==0); pix_tlast=(ox==X_PIX-1).
//   - Same handshake: pix_tvalid=1, clear inflight[cp], cp=(cp+1)%N_CORES, advance ox/oy with the same wrap as dx/dy.
//  Output register:
//   - tdata/tuser/tlast hold stable while tvalid && !tready.
//   - tvalid clears on accept if no new load happens in the same cycle.
//   - Simultaneous accept + load sustains 1 pixel/clk.
//  frame_done pulses on the cycle the pixel with tlast && oy wrapped (last line) is accepted.
//   After that pulse: dp, cp, and all counters are back at 0.
//  Latency: request handshake -> output valid = core latency + 1 clk.
//  A core asserting core_res_valid while not inflight is ignored; no ready is given.
//  Results from a non-cp core wait; no reordering buffer exists.
// TESTING
//  1. X_PIX=8, Y_PIX=4, N_CORES=4, 1-clk cores returning x+8*y, tready=1
//     -> tdata 0..31 in order; tuser only on beat 0; tlast on beats 7,15,23,31; frame_done once.
//  2. Same, cores with random latency 1-20 clk
//     -> output order identical to scenario 1; never >1 inflight per core.
//  3. tready random 50%
//     -> no beat lost or duplicated; tdata/tuser/tlast stable while stalled.
//  4. enable dropped at pixel 10
//     -> frame completes to 31, frame_done pulses, busy=0, no further req_valid.
//  5. enable held high for 3 frames
//     -> 96 beats; tuser on beats 0,32,64; dp/cp restart at 0 each frame.
//  6. periph_resetn low at pixel 13, then release
//     -> outputs 0 immediately; next frame starts at (0,0) with tuser.

Source files
------------

// File: rtl/fractal_pixel_scheduler.sv
// Raster-order pixel scheduler: hands (x,y) to N_CORES iteration engines round-robin
// and collects their counts in the same order into an AXI-Stream style pixel output.
module fractal_pixel_scheduler #(
    parameter int X_PIX   = 640,
    parameter int Y_PIX   = 480,
    parameter int N_CORES = 4,
    parameter int COORD_W = 10,
    parameter int ITER_W  = 8
) (
    input  logic                        out_stream_aclk,
    input  logic                        periph_resetn,
    input  logic                        enable,
    output logic [N_CORES-1:0]          core_req_valid,
    output logic [COORD_W-1:0]          core_req_x,
    output logic [COORD_W-1:0]          core_req_y,
    input  logic [N_CORES-1:0]          core_req_ready,
    input  logic [N_CORES-1:0]          core_res_valid,
    input  logic [N_CORES*ITER_W-1:0]   core_res_iter,
    output logic [N_CORES-1:0]          core_res_ready,
    output logic [ITER_W-1:0]           pix_tdata,
    output logic                        pix_tvalid,
    input  logic                        pix_tready,
    output logic                        pix_tuser,
    output logic                        pix_tlast,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(N_CORES - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(X_PIX - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(Y_PIX - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     dp, cp;
    logic [COORD_W-1:0]   dx, dy, ox, oy;
    logic [N_CORES-1:0]   inflight, inflight_set, inflight_clr;
    logic                 pix_eof;
    logic                 req_hs, res_hs, pix_acc, out_space, issue_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign out_space  = !pix_tvalid || pix_tready;
    assign req_hs     = (state == RUN) && !inflight[dp] && core_req_ready[dp];
    assign res_hs     = inflight[cp] && core_res_valid[cp] && out_space;
    assign pix_acc    = pix_tvalid && pix_tready;
    assign frame_done = pix_acc && pix_eof;
    assign issue_last = req_hs && (dx == X_LAST) && (dy == Y_LAST);

    assign core_req_x = dx;
    assign core_req_y = dy;
    assign busy       = (state != IDLE);

    // One request and one result port are live at a time: the pointers define raster order.
    always_comb begin
        core_req_valid = '0;
        core_res_ready = '0;
        inflight_set   = '0;
        inflight_clr   = '0;
        if (state == RUN)
            core_req_valid[dp] = !inflight[dp];
        core_res_ready[cp] = inflight[cp] && out_space;
        if (req_hs)
            inflight_set[dp] = 1'b1;
        if (res_hs)
            inflight_clr[cp] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (issue_last) state_nxt = DRAIN;
            DRAIN:   if (frame_done) state_nxt = enable ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            dp <= '0;
            dx <= '0;
            dy <= '0;
        end else if (frame_done) begin
            dp <= '0;
            dx <= '0;
            dy <= '0;
        end else if (req_hs) begin
            dp <= ptr_inc(dp);
            if (dx == X_LAST) begin
                dx <= '0;
                dy <= (dy == Y_LAST) ? '0 : dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            cp <= '0;
            ox <= '0;
            oy <= '0;
        end else if (frame_done) begin
            cp <= '0;
            ox <= '0;
            oy <= '0;
        end else if (res_hs) begin
            cp <= ptr_inc(cp);
            if (ox == X_LAST) begin
                ox <= '0;
                oy <= (oy == Y_LAST) ? '0 : oy + 1'b1;
            end else begin
                ox <= ox + 1'b1;
            end
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn)
            inflight <= '0;
        else
            inflight <= (inflight | inflight_set) & ~inflight_clr;
    end

    // Output register; pix_eof marks the frame's final pixel so frame_done fires on its accept.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            pix_tdata  <= '0;
            pix_tvalid <= 1'b0;
            pix_tuser  <= 1'b0;
            pix_tlast  <= 1'b0;
            pix_eof    <= 1'b0;
        end else if (res_hs) begin
            pix_tdata  <= core_res_iter[int'(cp)*ITER_W +: ITER_W];
            pix_tvalid <= 1'b1;
            pix_tuser  <= (ox == '0) && (oy == '0);
            pix_tlast  <= (ox == X_LAST);
            pix_eof    <= (ox == X_LAST) && (oy == Y_LAST);
        end else if (pix_acc) begin
            pix_tvalid <= 1'b0;
            pix_tuser  <= 1'b0;
            pix_tlast  <= 1'b0;
            pix_eof    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fractal_pixel_scheduler.sv
// Directed bench for fractal_pixel_scheduler on an 8x4 frame with 4 modelled cores
// returning x+8*y, so the expected pixel stream is simply 0..31 per frame.
module tb_fractal_pixel_scheduler;

    localparam int XP = 8, YP = 4, NC = 4, CW = 10, IW = 8, FRAME = XP * YP;

    logic               clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [NC-1:0]      core_req_valid, core_req_ready, core_res_valid, core_res_ready;
    logic [CW-1:0]      core_req_x, core_req_y;
    logic [NC*IW-1:0]   core_res_iter;
    logic [IW-1:0]      pix_tdata;
    logic               pix_tvalid, pix_tready = 1'b1, pix_tuser, pix_tlast, busy, frame_done;

    fractal_pixel_scheduler #(.X_PIX(XP), .Y_PIX(YP), .N_CORES(NC), .COORD_W(CW), .ITER_W(IW)) dut (
        .out_stream_aclk(clk), .periph_resetn(rst_n), .enable(enable),
        .core_req_valid(core_req_valid), .core_req_x(core_req_x), .core_req_y(core_req_y),
        .core_req_ready(core_req_ready), .core_res_valid(core_res_valid),
        .core_res_iter(core_res_iter), .core_res_ready(core_res_ready),
        .pix_tdata(pix_tdata), .pix_tvalid(pix_tvalid), .pix_tready(pix_tready),
        .pix_tuser(pix_tuser), .pix_tlast(pix_tlast), .busy(busy), .frame_done(frame_done)
    );

    initial forever #5 clk = ~clk;

    int errors = 0, checks = 0;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // core models: one pixel each, programmable latency, result held until accepted
    logic [NC-1:0] hold = '0, rogue = '0, rq, rs;
    int            timer [NC];
    logic [IW-1:0] val [NC];
    logic [CW-1:0] sx, sy;
    logic          rand_lat = 1'b0, rand_rdy = 1'b0;
    int            viol = 0, issue_n = 0;

    assign core_req_ready = ~hold;
    always_comb begin
        core_res_valid = '0;
        core_res_iter  = '0;
        for (int k = 0; k < NC; k++) begin
            core_res_valid[k] = (hold[k] && timer[k] == 0) | rogue[k];
            core_res_iter[k*IW +: IW] = val[k];
        end
    end

    initial begin
        for (int k = 0; k < NC; k++) begin timer[k] = 0; val[k] = '0; end
        forever begin
            @(negedge clk);
            rq = core_req_valid & core_req_ready;
            rs = core_res_valid & core_res_ready & hold;
            sx = core_req_x;
            sy = core_req_y;
            if (!rst_n) begin
                rq = '0; rs = '0; issue_n = 0;
            end else begin
                if ($countones(core_req_valid) > 1 || $countones(core_res_ready) > 1) viol++;
                for (int k = 0; k < NC; k++) begin
                    if (core_req_valid[k] && hold[k]) viol++;
                    if (core_res_ready[k] && !hold[k]) viol++;
                    if (rq[k]) begin
                        chk("req_core", k, issue_n % NC);
                        chk("req_x", sx, issue_n % XP);
                        chk("req_y", sy, issue_n / XP);
                        issue_n = (issue_n + 1) % FRAME;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (!rst_n) hold = '0;
            else for (int k = 0; k < NC; k++) begin
                if (rs[k]) hold[k] = 1'b0;
                if (rq[k]) begin
                    hold[k]  = 1'b1;
                    val[k]   = IW'(int'(sx) + 8 * int'(sy));
                    timer[k] = rand_lat ? int'($urandom_range(0, 19)) : 0;
                end else if (hold[k] && timer[k] > 0) begin
                    timer[k]--;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1 pix_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // output monitor: expected beat n of a frame carries n, tuser at 0, tlast every 8th
    int n = 0, beats = 0, frames = 0, tusers = 0, fd_cnt = 0;
    logic prev_stall = 1'b0, p_user, p_last;
    logic [IW-1:0] p_data;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            n = 0; prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", pix_tvalid, 1);
                chk("stall_data", pix_tdata, p_data);
                chk("stall_user", pix_tuser, p_user);
                chk("stall_last", pix_tlast, p_last);
            end
            if (frame_done) fd_cnt++;
            if (pix_tvalid && pix_tready) begin
                chk("tdata", pix_tdata, n);
                chk("tuser", pix_tuser, n == 0);
                chk("tlast", pix_tlast, n % XP == XP - 1);
                chk("frame_done", frame_done, n == FRAME - 1);
                beats++;
                if (pix_tuser) tusers++;
                if (n == FRAME - 1) begin n = 0; frames++; end
                else n++;
            end
            prev_stall = pix_tvalid && !pix_tready;
            p_data = pix_tdata; p_user = pix_tuser; p_last = pix_tlast;
        end
    end

    task automatic wait_frames(input int tgt);
        int c = 0;
        while (frames < tgt && c < 5000) begin @(negedge clk); #2; c++; end
        chk("frames_reached", frames, tgt);
    endtask

    task automatic wait_beats(input int tgt);
        int c = 0;
        while (beats < tgt && c < 5000) begin @(negedge clk); #2; c++; end
        chk("beats_reached", beats >= tgt, 1);
    endtask

    task automatic idle_check(input string tag);
        int cnt = 0;
        repeat (2) @(negedge clk);
        #2 chk({tag, "_busy"}, busy, 0);
        repeat (20) begin @(negedge clk); #2; if (core_req_valid != '0) cnt++; end
        chk({tag, "_req"}, cnt, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tvalid"}, pix_tvalid, 0);
        chk({tag, "_tdata"}, pix_tdata, 0);
        chk({tag, "_tuser"}, pix_tuser, 0);
        chk({tag, "_tlast"}, pix_tlast, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fdone"}, frame_done, 0);
        chk({tag, "_reqv"}, core_req_valid, 0);
        chk({tag, "_resr"}, core_res_ready, 0);
    endtask

    int b0, t0, f0;
    initial begin
        #12 check_zero("reset");
        chk("reset_x", core_req_x, 0);
        @(negedge clk) rst_n = 1'b1;

        // stray result valids while nothing is in flight must be ignored
        rogue = '1;
        repeat (3) @(negedge clk);
        #2 chk("rogue_resr", core_res_ready, 0);
        chk("rogue_tvalid", pix_tvalid, 0);
        rogue = '0;

        // 1-clk cores, full-rate sink, single frame
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        wait_frames(1);
        chk("f1_beats", beats, 32);
        idle_check("f1");

        // random core latency, enable dropped at pixel 10
        rand_lat = 1'b1;
        b0 = beats;
        @(posedge clk); #1 enable = 1'b1;
        wait_beats(b0 + 10);
        @(posedge clk); #1 enable = 1'b0;
        wait_frames(2);
        chk("f2_beats", beats - b0, 32);
        idle_check("f2");

        // random latency plus 50% backpressure
        rand_rdy = 1'b1;
        b0 = beats;
        @(posedge clk); #1 enable = 1'b1;
        wait_beats(b0 + 10);
        @(posedge clk); #1 enable = 1'b0;
        wait_frames(3);
        chk("f3_beats", beats - b0, 32);
        idle_check("f3");

        // three frames back to back
        rand_lat = 1'b0; rand_rdy = 1'b0;
        b0 = beats; t0 = tusers; f0 = frames;
        @(posedge clk); #1 enable = 1'b1;
        wait_frames(f0 + 2);
        @(posedge clk); #1 enable = 1'b0;
        wait_frames(f0 + 3);
        chk("b2b_beats", beats - b0, 96);
        chk("b2b_tusers", tusers - t0, 3);
        idle_check("b2b");

        // asynchronous reset at pixel 13, then a clean frame from (0,0)
        b0 = beats; f0 = frames;
        @(posedge clk); #1 enable = 1'b1;
        wait_beats(b0 + 13);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_zero("midrst");
        #20 rst_n = 1'b1;
        b0 = beats; t0 = tusers;
        wait_beats(b0 + 5);
        @(posedge clk); #1 enable = 1'b0;
        wait_frames(f0 + 1);
        chk("rst_beats", beats - b0, 32);
        chk("rst_tuser", tusers - t0, 1);
        idle_check("rst");

        chk("protocol_viol", viol, 0);
        chk("fdone_count", fd_cnt, frames);
        chk("total_frames", frames, 7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
